axi_wr_sram_bridge: RTL



---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_wr_sram_bridge_if.sv | 48 ++++
 rtl/axi_burst_addr_gen.sv | 49 ++++
 rtl/axi_wr_sram_bridge.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM bridges: burst encodings, response
// codes and the write-bridge FSM state type.
package axi_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    localparam logic AXI_RESP_OKAY = 1'b0;
    localparam logic AXI_RESP_ERR  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_RESP = 2'b10
    } wr_state_e;

    // WRAP and the reserved encoding are both "not FIXED, not INCR".
    function automatic logic burst_is_wrap_or_rsvd(input logic [1:0] burst);
        return (burst == AXI_BURST_WRAP) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/axi_wr_sram_bridge_if.sv
// AXI write-path signal bundle (AW, W, B channels) used between a write
// master and the SRAM bridge.
interface axi_wr_sram_bridge_if #(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = 8
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic                  bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Burst address generator: latches the burst base address, size and type,
// then steps the byte address once per accepted beat. Shared with the
// read-side bridge, so it knows nothing about the write channel.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] cur_addr
);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [ADDR_WIDTH-1:0] step;

    // FIXED bursts never move; INCR, WRAP and reserved all step linearly.
    always_comb begin
        step = '0;
        if (burst_q != AXI_BURST_FIXED) begin
            step = ADDR_WIDTH'(1) << size_q;
        end
    end

    // Load on the AW handshake, advance on every beat; wraps mod 2^ADDR_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
        end else if (load) begin
            addr_q  <= base_addr;
            size_q  <= size;
            burst_q <= burst;
        end else if (advance) begin
            addr_q  <= addr_q + step;
        end
    end

    assign cur_addr = addr_q;

endmodule

// File: rtl/axi_wr_sram_bridge.sv
// AXI write receiver in front of a single-port SRAM. Accepts one burst at a
// time, writes each beat to the SRAM one cycle after its handshake, and
// returns a single B response per burst.
// Optional build macro AXI_WR_SRAM_ERR_CHECK_EN enables burst error checks
// (bad burst type/size, out-of-range word address, wlast mismatch).
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | awready high, waiting for an AW handshake
// ST_DATA | wready high, accepting beats until beat_cnt == awlen
// ST_RESP | bvalid high with latched bid/bresp, waiting for bready
module axi_wr_sram_bridge
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = 8,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    axi_wr_sram_bridge_if.slave          axi,
    output logic                         mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [STRB_WIDTH-1:0]        mem_wstrb
);

    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int OFF    = $clog2(STRB_WIDTH);

    wr_state_e             state_q, state_d;
    logic                  aw_ready, w_ready, b_valid;
    logic                  aw_hs, w_hs;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt;
    logic                  last_beat;
    logic [ID_WIDTH-1:0]   bid_q;
    logic                  bresp_q;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] word_full;
    logic                  aw_err;
    logic                  err_q;
    logic                  err_now;

    // Sideband fields that the bridge deliberately does not act on.
    logic unused_sideband;
    assign unused_sideband = ^{axi.awlock, axi.awcache, axi.awprot, axi.wlast};

    assign aw_hs     = axi.awvalid && aw_ready;
    assign w_hs      = axi.wvalid && w_ready;
    assign last_beat = (beat_cnt == len_q);
    assign word_full = cur_addr >> OFF;

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (aw_hs),
        .base_addr (axi.awaddr),
        .size      (axi.awsize),
        .burst     (axi.awburst),
        .advance   (w_hs),
        .cur_addr  (cur_addr)
    );

`ifdef AXI_WR_SRAM_ERR_CHECK_EN
    localparam logic [2:0]            SIZE_MAX  = 3'(OFF);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic beat_err;

    // Burst-level errors are known at AW time; beat-level ones per handshake.
    always_comb begin
        aw_err   = burst_is_wrap_or_rsvd(axi.awburst) || (axi.awsize > SIZE_MAX);
        beat_err = ({1'b0, word_full} >= DEPTH_EXT) || (axi.wlast != last_beat);
        err_now  = err_q || beat_err;
    end
`else
    // Without checks every burst is OKAY and every beat is written.
    always_comb begin
        aw_err  = 1'b0;
        err_now = err_q;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and channel ready/valid decode.
    always_comb begin
        state_d  = state_q;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                aw_ready = 1'b1;
                if (axi.awvalid) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                w_ready = 1'b1;
                if (axi.wvalid && last_beat) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                b_valid = 1'b1;
                if (axi.bready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst bookkeeping and the registered SRAM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q      <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            err_q     <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= AXI_RESP_OKAY;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_we <= 1'b0;
            if (aw_hs) begin
                id_q     <= axi.awid;
                len_q    <= axi.awlen;
                beat_cnt <= '0;
                err_q    <= aw_err;
            end
            if (w_hs) begin
                // Once a burst has errored, this and every later beat is dropped.
                mem_we    <= !err_now;
                mem_addr  <= MEM_AW'(word_full);
                mem_wdata <= axi.wdata;
                mem_wstrb <= axi.wstrb;
                beat_cnt  <= beat_cnt + 8'd1;
                err_q     <= err_now;
                if (last_beat) begin
                    bid_q   <= id_q;
                    bresp_q <= err_now ? AXI_RESP_ERR : AXI_RESP_OKAY;
                end
            end
        end
    end

    assign axi.awready = aw_ready;
    assign axi.wready  = w_ready;
    assign axi.bvalid  = b_valid;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;

endmodule
